// File: rtl/bg_scroll_fetcher_if.sv
// VRAM read port shared by the background fetch engine.
// Read data is valid exactly one cycle after the mem_rd strobe.
interface bg_scroll_fetcher_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (output mem_rd, output mem_addr, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/bg_scroll_fetcher.sv
// Scanline-buffered background renderer: per-line sequential VRAM fetch into a
// double-buffered line memory, with fine/coarse scrolling and registered pixel output.
module bg_scroll_fetcher #(
  parameter int unsigned       ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] PMB_BASE     = 'h000,
  parameter logic [ADDR_W-1:0] NTBL_BASE    = 'h800,
  parameter int unsigned       COLOR_OFFSET = 960,
  parameter int unsigned       ROWS         = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 xp,
  input  logic                       visible,
  input  logic                       fetch_start,
  input  logic [7:0]                 fetch_y,
  input  logic [7:0]                 scroll_x,
  input  logic [7:0]                 scroll_y,
  bg_scroll_fetcher_if.master        mem,
  output logic [1:0]                 r,
  output logic [1:0]                 g,
  output logic [1:0]                 b,
  output logic                       fetch_busy,
  output logic                       fetch_overrun
);
  localparam logic [8:0] LINES = 9'(ROWS * 8);

  typedef enum logic [2:0] {S_IDLE, S_COL, S_NT, S_ATTR, S_P0, S_P1, S_WR} state_t;

  state_t             r_state, w_next;
  logic               w_accept, w_rd;
  logic [ADDR_W-1:0]  w_addr, r_addr_hold;
  logic [18:0]        r_buf [2][33];
  logic               r_disp;
  logic [2:0]         r_fine, r_ty, r_col0, r_col1;
  logic [4:0]         r_coarse, r_row, w_col;
  logic [5:0]         r_e;
  logic [7:0]         r_attr, r_byte0;
  logic [8:0]         w_sy_raw, w_ys_raw, w_px;
  logic [7:0]         w_sy, w_ys;
  logic [2:0]         w_vy, w_color;
  logic [15:0]        w_line_raw, w_line_flip, w_line, w_shift;
  logic [18:0]        w_ent;
  logic [1:0]         w_pix, r_r, r_g, r_b;
  logic               r_overrun;

  assign w_accept = fetch_start && ({1'b0, fetch_y} < LINES);

  // Vertical scroll: both the offset and the sum wrap at the nametable height.
  assign w_sy_raw = {1'b0, scroll_y};
  assign w_sy     = 8'((w_sy_raw >= LINES) ? w_sy_raw - LINES : w_sy_raw);
  assign w_ys_raw = {1'b0, fetch_y} + {1'b0, w_sy};
  assign w_ys     = 8'((w_ys_raw >= LINES) ? w_ys_raw - LINES : w_ys_raw);

  assign w_col   = r_coarse + r_e[4:0];
  assign w_vy    = r_attr[5] ? ~r_ty : r_ty;
  assign w_color = r_attr[7] ? r_col1 : r_col0;

  always_comb begin
    w_line_raw = {r_byte0, mem.mem_data};
    w_line_flip = '0;
    for (int unsigned i = 0; i < 8; i++)
      w_line_flip[2*i +: 2] = w_line_raw[14-2*i +: 2];
    w_line = r_attr[6] ? w_line_flip : w_line_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_addr = r_addr_hold;
    unique case (r_state)
      S_IDLE: ;
      S_COL: begin
        w_rd   = 1'b1;
        w_addr = NTBL_BASE + ADDR_W'(COLOR_OFFSET);
        w_next = S_NT;
      end
      S_NT: begin
        w_rd   = 1'b1;
        w_addr = NTBL_BASE + ADDR_W'({r_row, w_col});
        w_next = S_ATTR;
      end
      S_ATTR: w_next = S_P0;
      S_P0: begin
        w_rd   = 1'b1;
        w_addr = PMB_BASE + ADDR_W'({r_attr[4:0], w_vy, 1'b0});
        w_next = S_P1;
      end
      S_P1: begin
        w_rd   = 1'b1;
        w_addr = PMB_BASE + ADDR_W'({r_attr[4:0], w_vy, 1'b1});
        w_next = (r_e == 6'd32) ? S_WR : S_NT;
      end
      S_WR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_accept) w_next = S_COL;
  end

  assign mem.mem_rd   = w_rd;
  assign mem.mem_addr = w_addr;
  assign fetch_busy   = (r_state != S_IDLE);

  // An entry is written one tile late: NT of tile e commits tile e-1 using
  // the second pattern byte that is arriving on mem_data in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned bi = 0; bi < 2; bi++)
        for (int unsigned i = 0; i < 33; i++)
          r_buf[bi][i] <= '0;
      r_disp      <= 1'b0;
      r_fine      <= '0;
      r_coarse    <= '0;
      r_row       <= '0;
      r_ty        <= '0;
      r_e         <= '0;
      r_attr      <= '0;
      r_byte0     <= '0;
      r_col0      <= '0;
      r_col1      <= '0;
      r_addr_hold <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_rd) r_addr_hold <= w_addr;
      if (w_accept) begin
        if (r_state != S_IDLE) r_overrun <= 1'b1;
        r_disp   <= ~r_disp;
        r_fine   <= scroll_x[2:0];
        r_coarse <= scroll_x[7:3];
        r_row    <= w_ys[7:3];
        r_ty     <= w_ys[2:0];
        r_e      <= '0;
      end else begin
        case (r_state)
          S_NT: begin
            if (r_e == 6'd0) {r_col1, r_col0} <= mem.mem_data[5:0];
            else             r_buf[~r_disp][r_e - 6'd1] <= {w_color, w_line};
          end
          S_ATTR: r_attr <= mem.mem_data;
          S_P1: begin
            r_byte0 <= mem.mem_data;
            if (r_e != 6'd32) r_e <= r_e + 6'd1;
          end
          S_WR: r_buf[~r_disp][32] <= {w_color, w_line};
          default: ;
        endcase
      end
    end
  end

  assign w_px    = {1'b0, xp} + {6'b0, r_fine};
  assign w_ent   = r_buf[r_disp][w_px[8:3]];
  assign w_shift = w_ent[15:0] << {w_px[2:0], 1'b0};
  assign w_pix   = w_shift[15:14];

  always_ff @(posedge clk) begin
    if (rst || !visible) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end else begin
      r_r <= w_pix & {2{w_ent[18]}};
      r_g <= w_pix & {2{w_ent[17]}};
      r_b <= w_pix & {2{w_ent[16]}};
    end
  end

  assign r             = r_r;
  assign g             = r_g;
  assign b             = r_b;
  assign fetch_overrun = r_overrun;
endmodule

// File: tb/tb_bg_scroll_fetcher.sv
// Directed self-checking bench for bg_scroll_fetcher with a one-cycle-latency VRAM model.
module tb_bg_scroll_fetcher;
  logic       clk = 1'b0;
  logic       rst, visible, fetch_start, fetch_busy, fetch_overrun;
  logic [7:0] xp, fetch_y, scroll_x, scroll_y;
  logic [1:0] r, g, b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  vram [4096];
  logic [11:0] a_log [160];
  logic        rd_log [160];
  logic        busy_log [160];

  bg_scroll_fetcher_if #(.ADDR_W(12)) mem_if ();

  bg_scroll_fetcher #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .xp(xp), .visible(visible),
    .fetch_start(fetch_start), .fetch_y(fetch_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .mem(mem_if),
    .r(r), .g(g), .b(b),
    .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_if.mem_rd) mem_if.mem_data <= vram[mem_if.mem_addr];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses fetch_start in cycle 0 and logs the read port for n cycles.
  task automatic run_fetch(input logic [7:0] fy, input logic [7:0] sx, input logic [7:0] sy, input int n);
    fetch_y = fy; scroll_x = sx; scroll_y = sy; fetch_start = 1'b1;
    for (int c = 0; c < n; c++) begin
      a_log[c] = mem_if.mem_addr;
      rd_log[c] = mem_if.mem_rd;
      busy_log[c] = fetch_busy;
      tick();
      fetch_start = 1'b0;
    end
  endtask

  function automatic int unsigned rgb();
    return {r, g, b};
  endfunction

  int unsigned exp_pix [16] = '{0,1,2,3,3,2,1,0, 0,0,0,0,3,2,1,0};

  initial begin
    int busy_cnt, rd_cnt;
    for (int i = 0; i < 4096; i++) vram[i] = 8'h00;
    rst = 1'b1; visible = 1'b0; fetch_start = 1'b0;
    xp = '0; fetch_y = '0; scroll_x = '0; scroll_y = '0;
    tick(); tick();
    check_eq("rst_rgb", rgb(), 0);
    check_eq("rst_rd", mem_if.mem_rd, 0);
    check_eq("rst_addr", mem_if.mem_addr, 0);
    check_eq("rst_busy", fetch_busy, 0);
    check_eq("rst_ovr", fetch_overrun, 0);
    rst = 1'b0; visible = 1'b1;
    xp = 8'd0;   tick(); check_eq("rst_pix0", rgb(), 0);
    xp = 8'd200; tick(); check_eq("rst_pix200", rgb(), 0);

    // Basic fetch sequence
    vram[12'hBC0] = 8'h03; vram[12'h000] = 8'h1B; vram[12'h001] = 8'hE4;
    run_fetch(8'd0, 8'd0, 8'd0, 140);
    check_eq("seq_addr1", a_log[1], 12'hBC0);
    check_eq("seq_rd1", rd_log[1], 1);
    check_eq("seq_addr2", a_log[2], 12'h800);
    check_eq("seq_rd3", rd_log[3], 0);
    check_eq("seq_addr4", a_log[4], 12'h000);
    check_eq("seq_addr5", a_log[5], 12'h001);
    check_eq("seq_addr6", a_log[6], 12'h801);
    busy_cnt = 0;
    for (int c = 0; c < 140; c++) busy_cnt += int'(busy_log[c]);
    check_eq("busy_cnt", busy_cnt, 134);
    check_eq("busy_c0", busy_log[0], 0);
    check_eq("busy_c1", busy_log[1], 1);
    check_eq("busy_c134", busy_log[134], 1);
    check_eq("busy_c135", busy_log[135], 0);

    // Pixel output after second fetch_start
    run_fetch(8'd0, 8'd0, 8'd0, 140);
    for (int p = 0; p < 4; p++) begin
      xp = 8'(p); tick();
      check_eq("pix_gb", rgb(), {2'd0, 2'(p), 2'(p)});
    end
    xp = 8'd0; #1;
    check_eq("pix_latency_hold", rgb(), {2'd0, 2'd3, 2'd3});
    tick();
    check_eq("pix_latency_new", rgb(), 0);
    visible = 1'b0; xp = 8'd2; tick();
    check_eq("pix_invisible", rgb(), 0);
    visible = 1'b1;

    // Flips and colorselect
    vram[12'hBC0] = 8'h23;
    vram[12'h800] = 8'h60; vram[12'h801] = 8'hC1;
    vram[12'h00A] = 8'h1B; vram[12'h00B] = 8'hE4;
    vram[12'h014] = 8'h1B; vram[12'h015] = 8'h00;
    run_fetch(8'd2, 8'd0, 8'd0, 140);
    check_eq("flip_p0", a_log[4], 12'h00A);
    check_eq("flip_p1", a_log[5], 12'h00B);
    check_eq("flip_t1_p0", a_log[8], 12'h014);
    run_fetch(8'd0, 8'd0, 8'd0, 140);
    for (int p = 0; p < 16; p++) begin
      xp = 8'(p); tick();
      if (p < 8) check_eq("flip_pix_t0", rgb(), {2'd0, 2'(exp_pix[p]), 2'(exp_pix[p])});
      else       check_eq("flip_pix_t1", rgb(), {2'(exp_pix[p]), 4'd0});
    end

    // Rejected fetch_start: no read, no busy, no swap
    xp = 8'd12; tick();
    run_fetch(8'd240, 8'd0, 8'd0, 10);
    rd_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      rd_cnt += int'(rd_log[c]);
      busy_cnt += int'(busy_log[c]);
    end
    check_eq("rej_rd", rd_cnt, 0);
    check_eq("rej_busy", busy_cnt, 0);
    tick();
    check_eq("rej_noswap", rgb(), {2'd3, 4'd0});

    // Scroll and wrap
    vram[12'h01A] = 8'h1B; vram[12'h01B] = 8'h00;
    run_fetch(8'd10, 8'd13, 8'd235, 140);
    check_eq("scr_nt_e0", a_log[2], 12'h801);
    check_eq("scr_p0_e0", a_log[4], 12'h01A);
    check_eq("scr_nt_e1", a_log[6], 12'h802);
    check_eq("scr_nt_e31", a_log[126], 12'h800);
    run_fetch(8'd10, 8'd13, 8'd235, 140);
    xp = 8'd0;   tick(); check_eq("scr_xp0", rgb(), {2'd2, 4'd0});
    xp = 8'd3;   tick(); check_eq("scr_xp3", rgb(), 0);
    xp = 8'd5;   tick(); check_eq("scr_xp5", rgb(), {2'd0, 2'd2, 2'd2});
    xp = 8'd255; tick(); check_eq("scr_xp255", rgb(), {2'd3, 4'd0});

    // Overrun
    fetch_y = 8'd0; scroll_x = 8'd0; scroll_y = 8'd0; fetch_start = 1'b1;
    tick(); fetch_start = 1'b0;
    for (int c = 1; c < 50; c++) tick();
    check_eq("ovr_before", fetch_overrun, 0);
    check_eq("ovr_busy50", fetch_busy, 1);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    check_eq("ovr_flag", fetch_overrun, 1);
    check_eq("ovr_addr", mem_if.mem_addr, 12'hBC0);
    check_eq("ovr_rd", mem_if.mem_rd, 1);
    for (int c = 0; c < 140; c++) tick();
    check_eq("ovr_done", fetch_busy, 0);
    check_eq("ovr_sticky", fetch_overrun, 1);

    // Reset mid-fetch
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1; tick();
    check_eq("mrst_busy", fetch_busy, 0);
    check_eq("mrst_rd", mem_if.mem_rd, 0);
    check_eq("mrst_addr", mem_if.mem_addr, 0);
    check_eq("mrst_ovr", fetch_overrun, 0);
    rst = 1'b0; xp = 8'd12; tick();
    check_eq("mrst_pix", rgb(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
